// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker memory-port arbiter.
// Covers the arbiter FSM states, the requester identity and the memory access sizes.
package tinker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam logic MSIZE_W32 = 1'b0;
  localparam logic MSIZE_W64 = 1'b1;

  localparam int DATA_W   = 64;
  localparam int INSN_W   = 32;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/tinker_arb_prio.sv
// Winner selection between fetch and data requesters: data-first, with a
// saturating counter that hands the port to fetch after STARVE_LIMIT data wins.
module tinker_arb_prio
  import tinker_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    if_req,
  input  logic    d_req,
  input  logic    arb_en,
  output req_id_t winner
);

  localparam logic [STARVE_W-1:0] LIMIT   = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] CNT_ONE = STARVE_W'(1);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;

  always_comb begin
    winner = REQ_D;
    if (if_req && (!d_req || (starve_cnt_q == LIMIT))) begin
      winner = REQ_IF;
    end
  end

  // Only a data win while fetch is waiting counts towards starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if ((winner == REQ_D) && if_req) begin
        starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + CNT_ONE;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the single Tinker memory port between instruction fetch and load/store,
// one outstanding transaction at a time, routing each response to its issuer.
module tinker_mem_arbiter
  import tinker_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic              m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [63:0]       m_rdata,
  output logic              busy
);

  arb_state_t          state_q, state_d;
  req_id_t             owner_q, owner_d;
  req_id_t             winner;
  logic                arb_en;

  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic                m_size_q, m_size_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [INSN_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  assign arb_en = (state_q == IDLE) && (if_req || d_req);

  tinker_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .arb_en (arb_en),
    .winner (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (arb_en) begin
          owner_d = winner;
          m_req_d = 1'b1;
          state_d = ISSUE;
          if (winner == REQ_IF) begin
            if_gnt_d  = 1'b1;
            m_we_d    = 1'b0;
            m_size_d  = MSIZE_W32;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
          end else begin
            d_gnt_d   = 1'b1;
            m_we_d    = d_we;
            m_size_d  = MSIZE_W64;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
        end
      end

      ISSUE: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end
      end

      // Fetch never writes, so m_we_q alone tells a store ack from load data.
      WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
          if (owner_q == REQ_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = m_rdata[INSN_W-1:0];
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_we_q ? '0 : m_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_IF;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_size_q    <= MSIZE_W32;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_size    = m_size_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed bench for tinker_mem_arbiter: a per-cycle vector table for fetch and
// fetch/data contention, then hand sequences for starvation, slow store, reset and stray responses.
module tb_tinker_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic        m_size;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [63:0] m_rdata;
  logic        busy;

  always #5 clk = ~clk;

  tinker_mem_arbiter #(
    .ADDR_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, m_size, busy}), 64'd0);
    check({tag, " m_addr"}, 64'(m_addr), 64'd0);
    check({tag, " m_wdata"}, m_wdata, 64'd0);
    check({tag, " if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, " d_rdata"}, d_rdata, 64'd0);
  endtask

  // e_ctl = {if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, busy}; e_wesz = {m_we, m_size}
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic [5:0]  e_ctl;
    logic [1:0]  e_wesz;
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
    logic [31:0] e_if_rdata;
    logic [63:0] e_d_rdata;
  } vec_t;

  vec_t vecs[13];

  string gs;
  int    viol;
  logic  acc;

  initial begin
    vecs[0]  = '{1'b1, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0,
                 6'b000000, 2'b00, '0, '0, '0, '0};
    vecs[1]  = '{1'b0, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0,
                 6'b100011, 2'b00, 32'h2000, '0, '0, '0};
    vecs[2]  = '{1'b0, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0,
                 6'b000001, 2'b00, '0, '0, '0, '0};
    vecs[3]  = '{1'b0, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 64'h0000_0000_C840_0004,
                 6'b000001, 2'b00, '0, '0, '0, '0};
    vecs[4]  = '{1'b0, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0,
                 6'b001000, 2'b00, '0, '0, 32'hC840_0004, '0};
    vecs[5]  = '{1'b0, 32'h2000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0,
                 6'b000000, 2'b00, '0, '0, 32'hC840_0004, '0};
    vecs[6]  = '{1'b1, 32'h2004, 1'b1, 1'b0, 32'h1_0000, '0, 1'b0, 1'b0, '0,
                 6'b000000, 2'b00, '0, '0, 32'hC840_0004, '0};
    vecs[7]  = '{1'b1, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b1, 1'b0, '0,
                 6'b010011, 2'b01, 32'h1_0000, '0, 32'hC840_0004, '0};
    vecs[8]  = '{1'b1, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b0, 1'b1, 64'h1122_3344_5566_7788,
                 6'b000001, 2'b00, '0, '0, 32'hC840_0004, '0};
    vecs[9]  = '{1'b1, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b0, 1'b0, '0,
                 6'b000100, 2'b00, '0, '0, 32'hC840_0004, 64'h1122_3344_5566_7788};
    vecs[10] = '{1'b0, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b1, 1'b0, '0,
                 6'b100011, 2'b00, 32'h2004, '0, 32'hC840_0004, 64'h1122_3344_5566_7788};
    vecs[11] = '{1'b0, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b0, 1'b1, 64'hAAAA_AAAA_0000_BEEF,
                 6'b000001, 2'b00, '0, '0, 32'hC840_0004, 64'h1122_3344_5566_7788};
    vecs[12] = '{1'b0, 32'h2004, 1'b0, 1'b0, 32'h1_0000, '0, 1'b0, 1'b0, '0,
                 6'b001000, 2'b00, '0, '0, 32'h0000_BEEF, 64'h1122_3344_5566_7788};

    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Fetch-only transaction, then fetch and load contending.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("v%0d ctl", i),
            64'({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, busy}), 64'(vecs[i].e_ctl));
      if (vecs[i].e_ctl[1]) begin
        check($sformatf("v%0d we_size", i), 64'({m_we, m_size}), 64'(vecs[i].e_wesz));
        check($sformatf("v%0d m_addr", i), 64'(m_addr), 64'(vecs[i].e_addr));
        check($sformatf("v%0d m_wdata", i), m_wdata, vecs[i].e_wdata);
      end
      check($sformatf("v%0d if_rdata", i), 64'(if_rdata), 64'(vecs[i].e_if_rdata));
      check($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
      if_req   = vecs[i].if_req;
      if_addr  = vecs[i].if_addr;
      d_req    = vecs[i].d_req;
      d_we     = vecs[i].d_we;
      d_addr   = vecs[i].d_addr;
      d_wdata  = vecs[i].d_wdata;
      m_ready  = vecs[i].m_ready;
      m_rvalid = vecs[i].m_rvalid;
      m_rdata  = vecs[i].m_rdata;
    end

    // Starvation: both requesters held, memory answers as fast as allowed.
    gs      = "";
    viol    = 0;
    acc     = 1'b0;
    if_addr = 32'h3000;
    d_addr  = 32'h4000;
    d_we    = 1'b0;
    d_wdata = '0;
    m_rdata = 64'hCAFE_F00D_1234_5678;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int c = 0; c < 60 && gs.len() < 6; c++) begin
      @(posedge clk);
      #1;
      if (if_gnt) gs = {gs, "I"};
      if (d_gnt) gs = {gs, "D"};
      if ((if_gnt && if_rvalid) || (d_gnt && d_rvalid) || (if_rvalid && d_rvalid)) viol++;
      m_rvalid = acc;
      m_ready  = m_req;
      acc      = m_req;
    end
    checks++;
    if (gs != "DDDDID") begin
      errors++;
      $display("FAIL starve_order: got %s, expected DDDDID", gs);
    end
    check("pulse_overlap", 64'(viol), 64'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      m_rvalid = acc;
      m_ready  = m_req;
      acc      = m_req;
    end
    check("drain idle", 64'(busy), 64'd0);
    check("starve d_rdata", d_rdata, 64'hCAFE_F00D_1234_5678);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;

    // Store with m_ready held off for three cycles.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h8_0000;
    d_wdata = 64'hDEAD_BEEF_0123_4567;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("st%0d d_gnt", k), 64'(d_gnt), (k == 1) ? 64'd1 : 64'd0);
      check($sformatf("st%0d m_req/we/size", k), 64'({m_req, m_we, m_size}), 64'b111);
      check($sformatf("st%0d m_addr", k), 64'(m_addr), 64'h8_0000);
      check($sformatf("st%0d m_wdata", k), m_wdata, 64'hDEAD_BEEF_0123_4567);
      if (k == 1) d_req = 1'b0;
      if (k == 4) m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("st wait", 64'({m_req, busy, d_rvalid}), 64'b010);
    m_ready  = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    check("st ack", 64'({d_rvalid, if_rvalid, busy}), 64'b100);
    check("st d_rdata", d_rdata, 64'd0);
    m_rvalid = 1'b0;
    @(posedge clk);
    #1;
    check("st after", 64'({d_rvalid, busy}), 64'b00);

    // Reset while waiting for a fetch response, then a late response.
    if_req  = 1'b1;
    if_addr = 32'h5000;
    @(posedge clk);
    #1;
    check("rst gnt", 64'({if_gnt, m_req}), 64'b11);
    if_req  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst in wait", 64'({m_req, busy}), 64'b01);
    m_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async rst");
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 64'h0000_0000_1357_9BDF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stray%0d", k), 64'({if_rvalid, d_rvalid, busy}), 64'b000);
      check($sformatf("stray%0d if_rdata", k), 64'(if_rdata), 64'd0);
    end
    m_rvalid = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h6000;
    @(posedge clk);
    #1;
    check("post stray gnt", 64'({if_gnt, d_gnt, m_req, busy}), 64'b1011);
    check("post stray addr", 64'(m_addr), 64'h6000);
    if_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
